memory_wait_controller: RTL and testbench

Controller for the memory-wait pipeline stage. Decodes the instruction currently held in the memory-wait stage; for ARM single-data-transfer instructions (LDR/STR) it issues a data-memory request and freezes the pipeline until memory signals ready and a minimum wait has elapsed. It then pulses a one-cycle `status_rdy` toward the pipeline controller. It sits beside `memory_wait_pipeline_unit`, filling the controller slot of the memory-wait stage.

---
 rtl/memory_wait_controller.sv | 147 ++++++++++++++
 tb/tb_memory_wait_controller.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_wait_controller.sv
// memory_wait_controller
//   Controller for the memory-wait pipeline stage. Decodes the instruction held
//   in the stage; for LDR/STR it issues a data-memory request, freezes the
//   pipeline until memory is ready and MIN_WAIT cycles have elapsed, then
//   pulses status_rdy for one cycle.
//
//   Optional feature: define MEMORY_WAIT_TIMEOUT_EN to build the WAIT-cycle
//   timeout (ERR state, sticky timeout_err). Without it timeout_err is 0.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   instr_in     instruction in the memory-wait stage
//   instr_valid  instr_in is a live, non-bubble instruction
//   mem_rdy      data memory has completed the access
//   mem_rd_en    load request, held during WAIT
//   mem_wr_en    store request, held during WAIT
//   stall_out    freeze upstream stages (combinational)
//   status_rdy   one-cycle pulse: memory access complete
//   timeout_err  sticky timeout flag
//   wait_count   WAIT cycles taken by the last completed access
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no access in flight; stall asserted combinationally on detect
// WAIT  | request held, counting cycles until qualified mem_rdy
// DONE  | one-cycle status_rdy pulse, always returns to IDLE
// ERR   | timeout hit (timeout build only): flag set, no status pulse
module memory_wait_controller #(
  parameter int MIN_WAIT = 1,
  parameter int TIMEOUT  = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_in,
  input  logic        instr_valid,
  input  logic        mem_rdy,
  output logic        mem_rd_en,
  output logic        mem_wr_en,
  output logic        stall_out,
  output logic        status_rdy,
  output logic        timeout_err,
  output logic [7:0]  wait_count
);

  if (MIN_WAIT < 1 || MIN_WAIT > 254) begin : g_bad_min_wait
    $error("memory_wait_controller: MIN_WAIT out of range 1..254");
  end
  if (TIMEOUT <= MIN_WAIT || TIMEOUT > 255) begin : g_bad_timeout
    $error("memory_wait_controller: TIMEOUT must satisfy MIN_WAIT < TIMEOUT <= 255");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
`ifdef MEMORY_WAIT_TIMEOUT_EN
    , S_ERR = 2'd3
`endif
  } state_t;

  localparam logic [8:0] MIN_WAIT_W = 9'(MIN_WAIT);

  state_t     state, state_nxt;
  logic [7:0] cnt;
  logic       load_q;
  logic [8:0] cnt_p1;
  logic       is_mem;
  logic       is_load;
  logic       complete;
  logic       unused_instr_bits;

  assign is_mem  = instr_valid && (instr_in[27:26] == 2'b01) && (instr_in[31:28] != 4'hF);
  assign is_load = instr_in[20];
  assign unused_instr_bits = ^{instr_in[25:21], instr_in[19:0]};

  // 9-bit so the saturated count (255) + 1 does not wrap in the compares.
  assign cnt_p1   = {1'b0, cnt} + 9'd1;
  assign complete = mem_rdy && (cnt_p1 >= MIN_WAIT_W);

`ifdef MEMORY_WAIT_TIMEOUT_EN
  localparam logic [8:0] TIMEOUT_W = 9'(TIMEOUT);
  logic expire;
  logic timeout_q;
  // Completion takes priority over expiry in the same cycle.
  assign expire = !complete && (cnt_p1 == TIMEOUT_W);
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (is_mem) state_nxt = S_WAIT;
      S_WAIT: begin
        if (complete) state_nxt = S_DONE;
`ifdef MEMORY_WAIT_TIMEOUT_EN
        else if (expire) state_nxt = S_ERR;
`endif
      end
      // The same instruction is still in the stage, so DONE never re-decodes.
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Cycle counter, access direction and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= 8'd0;
      load_q     <= 1'b0;
      wait_count <= 8'd0;
    end else begin
      if (state == S_IDLE && is_mem) begin
        cnt    <= 8'd0;
        load_q <= is_load;
      end else if (state == S_WAIT) begin
        if (complete)           wait_count <= cnt_p1[8] ? 8'hFF : cnt_p1[7:0];
        else if (cnt != 8'hFF)  cnt        <= cnt + 8'd1;
      end
    end
  end

`ifdef MEMORY_WAIT_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst)                             timeout_q <= 1'b0;
    else if (state == S_WAIT && expire)  timeout_q <= 1'b1;
  end
  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

  // Output logic
  always_comb begin
    mem_rd_en  = (state == S_WAIT) && load_q;
    mem_wr_en  = (state == S_WAIT) && !load_q;
    status_rdy = (state == S_DONE);
    stall_out  = (state == S_WAIT) || ((state == S_IDLE) && is_mem);
  end

endmodule

// File: tb/tb_memory_wait_controller.sv
module tb_memory_wait_controller;

  localparam logic [31:0] LDR     = 32'hE5912000;
  localparam logic [31:0] STR     = 32'hE5812000;
  localparam logic [31:0] ADD     = 32'hE0810002;
  localparam logic [31:0] LDR_NV  = 32'hF5912000;
  localparam int          NEVER   = 1000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_in;
  logic        instr_valid;
  logic        mem_rdy;

  logic rd1, wr1, stall1, stat1, terr1;
  logic rd3, wr3, stall3, stat3, terr3;
  logic [7:0] wc1, wc3;

  int tests_run    = 0;
  int tests_failed = 0;

  // Per-run tallies filled by run_access
  int n_stall1, n_rd1, n_wr1, n_stat1, stat_cyc1;
  int n_stall3, n_rd3, n_stat3, stat_cyc3;

  always #5 clk = ~clk;

  memory_wait_controller #(.MIN_WAIT(1), .TIMEOUT(8)) dut1 (
    .clk(clk), .rst(rst), .instr_in(instr_in), .instr_valid(instr_valid),
    .mem_rdy(mem_rdy), .mem_rd_en(rd1), .mem_wr_en(wr1), .stall_out(stall1),
    .status_rdy(stat1), .timeout_err(terr1), .wait_count(wc1)
  );

  memory_wait_controller #(.MIN_WAIT(3), .TIMEOUT(8)) dut3 (
    .clk(clk), .rst(rst), .instr_in(instr_in), .instr_valid(instr_valid),
    .mem_rdy(mem_rdy), .mem_rd_en(rd3), .mem_wr_en(wr3), .stall_out(stall3),
    .status_rdy(stat3), .timeout_err(terr3), .wait_count(wc3)
  );

  // Cycle c starts just after a rising edge; c=0 is the detect cycle, so
  // cycle k (k>=1) is the k-th WAIT cycle. mem_rdy is high from cycle rdy_at.
  // instr_valid drops once dut1 reports completion or timeout.
  task automatic run_access(input logic [31:0] ins, input logic vld,
                            input int rdy_at, input int ncyc);
    logic done;
    done = 1'b0;
    n_stall1 = 0; n_rd1 = 0; n_wr1 = 0; n_stat1 = 0; stat_cyc1 = -1;
    n_stall3 = 0; n_rd3 = 0; n_stat3 = 0; stat_cyc3 = -1;
    instr_in = ins;
    instr_valid = vld;
    for (int c = 0; c < ncyc; c++) begin
      mem_rdy = (c >= rdy_at);
      #1;
      n_stall1 += int'(stall1); n_rd1 += int'(rd1); n_wr1 += int'(wr1);
      n_stall3 += int'(stall3); n_rd3 += int'(rd3);
      if (stat1) begin n_stat1++; if (stat_cyc1 < 0) stat_cyc1 = c; end
      if (stat3) begin n_stat3++; if (stat_cyc3 < 0) stat_cyc3 = c; end
      if (stat1 || terr1) done = 1'b1;
      @(posedge clk); #1;
      if (done) instr_valid = 1'b0;
    end
  endtask

  task automatic settle();
    instr_valid = 1'b0;
    mem_rdy = 1'b1;
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    instr_valid = 1'b0;
    mem_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; instr_in = LDR; instr_valid = 1'b0; mem_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({rd1, wr1, stall1, stat1, terr1, wc1} !== 13'd0) begin
      tests_failed++;
      $display("FAIL reset_dut1 got rd=%b wr=%b stall=%b stat=%b terr=%b wc=%0d want all 0",
               rd1, wr1, stall1, stat1, terr1, wc1);
    end
    tests_run++;
    if ({rd3, wr3, stall3, stat3, terr3, wc3} !== 13'd0) begin
      tests_failed++;
      $display("FAIL reset_dut3 got rd=%b wr=%b stall=%b stat=%b terr=%b wc=%0d want all 0",
               rd3, wr3, stall3, stat3, terr3, wc3);
    end
    rst = 1'b0;
  endtask

  task automatic test_ldr_best_case();
    run_access(LDR, 1'b1, 0, 8);
    tests_run++;
    if (n_stall1 !== 2 || n_rd1 !== 1 || n_wr1 !== 0) begin
      tests_failed++;
      $display("FAIL ldr_counts got stall=%0d rd=%0d wr=%0d want 2 1 0", n_stall1, n_rd1, n_wr1);
    end
    tests_run++;
    if (n_stat1 !== 1 || stat_cyc1 !== 2) begin
      tests_failed++;
      $display("FAIL ldr_status got pulses=%0d cycle=%0d want 1 at 2", n_stat1, stat_cyc1);
    end
    tests_run++;
    if (wc1 !== 8'd1) begin
      tests_failed++;
      $display("FAIL ldr_wait_count got %0d want 1", wc1);
    end
    tests_run++;
    if (wc3 !== 8'd3 || stat_cyc3 !== 4 || n_stall3 !== 4 || n_rd3 !== 3) begin
      tests_failed++;
      $display("FAIL min_wait3 got wc=%0d stat_cyc=%0d stall=%0d rd=%0d want 3 4 4 3",
               wc3, stat_cyc3, n_stall3, n_rd3);
    end
    settle();
  endtask

  task automatic test_str_late_ready();
    run_access(STR, 1'b1, 4, 9);
    tests_run++;
    if (n_wr1 !== 4 || n_rd1 !== 0 || n_stall1 !== 5) begin
      tests_failed++;
      $display("FAIL str_counts got wr=%0d rd=%0d stall=%0d want 4 0 5", n_wr1, n_rd1, n_stall1);
    end
    tests_run++;
    if (n_stat1 !== 1 || stat_cyc1 !== 5 || wc1 !== 8'd4) begin
      tests_failed++;
      $display("FAIL str_done got pulses=%0d cycle=%0d wc=%0d want 1 5 4", n_stat1, stat_cyc1, wc1);
    end
    tests_run++;
    if (wc3 !== 8'd4 || stat_cyc3 !== 5) begin
      tests_failed++;
      $display("FAIL str_min_wait3 got wc=%0d cycle=%0d want 4 5", wc3, stat_cyc3);
    end
    settle();
  endtask

  task automatic test_non_memory();
    logic [31:0] ins [3];
    logic        vld [3];
    ins[0] = ADD;    vld[0] = 1'b1;
    ins[1] = LDR_NV; vld[1] = 1'b1;
    ins[2] = LDR;    vld[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      run_access(ins[i], vld[i], 0, 4);
      tests_run++;
      if (n_stall1 + n_rd1 + n_wr1 + n_stat1 + n_stall3 + n_stat3 !== 0) begin
        tests_failed++;
        $display("FAIL non_mem_%0d got stall=%0d rd=%0d wr=%0d stat=%0d want all 0",
                 i, n_stall1, n_rd1, n_wr1, n_stat1);
      end
    end
    settle();
  endtask

  task automatic test_back_to_back();
    logic [5:0] stat_bits;
    int         n_st;
    stat_bits = 6'd0;
    n_st = 0;
    instr_in = LDR; instr_valid = 1'b1; mem_rdy = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      stat_bits[c] = stat1;
      n_st += int'(stall1);
      @(posedge clk); #1;
    end
    tests_run++;
    if (stat_bits !== 6'b100100 || n_st !== 4) begin
      tests_failed++;
      $display("FAIL back_to_back got status=%b stall=%0d want 100100 4", stat_bits, n_st);
    end
    settle();
  endtask

`ifdef MEMORY_WAIT_TIMEOUT_EN
  task automatic test_timeout();
    run_access(LDR, 1'b1, NEVER, 12);
    tests_run++;
    if (n_stall1 !== 9 || n_rd1 !== 8 || n_stat1 !== 0) begin
      tests_failed++;
      $display("FAIL timeout_counts got stall=%0d rd=%0d stat=%0d want 9 8 0", n_stall1, n_rd1, n_stat1);
    end
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (terr1 !== 1'b1 || terr3 !== 1'b1) begin
      tests_failed++;
      $display("FAIL timeout_sticky got terr1=%b terr3=%b want 1 1", terr1, terr3);
    end
    do_reset();
    run_access(LDR, 1'b1, 8, 12);
    tests_run++;
    if (n_stat1 !== 1 || stat_cyc1 !== 9 || wc1 !== 8'd8 || terr1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_edge got pulses=%0d cycle=%0d wc=%0d terr=%b want 1 9 8 0",
               n_stat1, stat_cyc1, wc1, terr1);
    end
    settle();
  endtask
`else
  task automatic test_timeout();
    run_access(LDR, 1'b1, NEVER, 20);
    tests_run++;
    if (n_stall1 !== 20 || n_rd1 !== 19 || n_stat1 !== 0 || terr1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL no_timeout got stall=%0d rd=%0d stat=%0d terr=%b want 20 19 0 0",
               n_stall1, n_rd1, n_stat1, terr1);
    end
    do_reset();
  endtask
`endif

  task automatic test_reset_mid_wait();
    instr_in = LDR; instr_valid = 1'b1; mem_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    instr_valid = 1'b0;
    #1;
    tests_run++;
    if (rd1 !== 1'b1 || stall1 !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_wait_pre got rd=%b stall=%b want 1 1", rd1, stall1);
    end
    @(posedge clk); #1;
    tests_run++;
    if (rd1 !== 1'b0 || wr1 !== 1'b0 || stall1 !== 1'b0 || stat1 !== 1'b0 || rd3 !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_wait_rst got rd=%b wr=%b stall=%b stat=%b want 0 0 0 0",
               rd1, wr1, stall1, stat1);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (stat1 !== 1'b0 || stall1 !== 1'b0 || rd1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_wait_after got stat=%b stall=%b rd=%b want 0 0 0", stat1, stall1, rd1);
    end
  endtask

  initial begin
    test_reset();
    test_ldr_best_case();
    test_str_late_ready();
    test_non_memory();
    test_back_to_back();
    test_timeout();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
